// File: rtl/expmu_scheduler.sv
// expmu_scheduler: sweeps a small (mu, S0) asset table over time steps T_MIN..T_MAX,
// issuing one operand set per cycle to a fixed-latency exp datapath, and tags each
// returning result with its {asset, t} result-memory address.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   iStart / iAbort               one-cycle run request / cancel request
//   iLoadEn, iLoadIdx, iLoadMu/S  asset-table write port (idle only)
//   iResult                       datapath result, forwarded as write data
//   oIssue, oT, oMu, oS           operands to datapath (zero when not issuing)
//   oWrEn, oWrAddr, oWrData       result-memory write port
//   oBusy, oDone, oAborted        run status
module expmu_scheduler #(
    parameter int unsigned N_ASSETS = 4,
    parameter int unsigned LOGN     = 2,
    parameter int unsigned T_MIN    = 343,
    parameter int unsigned T_MAX    = 511,
    parameter int unsigned LOGT     = 9,
    parameter int unsigned PIPE_LAT = 12
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iStart,
    input  logic                 iAbort,
    input  logic                 iLoadEn,
    input  logic [LOGN-1:0]      iLoadIdx,
    input  logic [17:0]          iLoadMu,
    input  logic [17:0]          iLoadS,
    input  logic [17:0]          iResult,
    output logic                 oIssue,
    output logic [LOGT-1:0]      oT,
    output logic [17:0]          oMu,
    output logic [17:0]          oS,
    output logic                 oWrEn,
    output logic [LOGN+LOGT-1:0] oWrAddr,
    output logic [17:0]          oWrData,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oAborted
);

    localparam int unsigned TagW = LOGN + LOGT;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StIssue  = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    localparam logic [LOGT-1:0] TMin      = LOGT'(T_MIN);
    localparam logic [LOGT-1:0] TMax      = LOGT'(T_MAX);
    localparam logic [LOGN-1:0] LastAsset = LOGN'(N_ASSETS - 1);

    logic [1:0]          state_q, state_d;
    logic [LOGT-1:0]     t_q, t_d;
    logic [LOGN-1:0]     asset_q, asset_d;
    logic [17:0]         mu_q [N_ASSETS];
    logic [17:0]         s_q  [N_ASSETS];
    logic [PIPE_LAT-1:0] valid_q, valid_d;
    logic [TagW-1:0]     tag_q [PIPE_LAT];

    logic abort_hit;
    logic issue;
    logic load_ok;

    // Abort only matters while a run is producing or draining results.
    assign abort_hit = iAbort && ((state_q == StIssue) || (state_q == StDrain));
    assign issue     = (state_q == StIssue) && !iAbort;
    assign load_ok   = iLoadEn && (state_q == StIdle) && (32'(iLoadIdx) < N_ASSETS);

    // Asset table
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(N_ASSETS); i++) begin
                mu_q[i] <= '0;
                s_q[i]  <= '0;
            end
        end else if (load_ok) begin
            mu_q[iLoadIdx] <= iLoadMu;
            s_q[iLoadIdx]  <= iLoadS;
        end
    end

    // Sequencer
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        asset_d = asset_q;
        case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d = StIssue;
                    t_d     = TMin;
                    asset_d = '0;
                end
            end
            StIssue: begin
                if (iAbort) begin
                    state_d = StIdle;
                end else if (t_q == TMax) begin
                    t_d     = TMin;
                    asset_d = asset_q + LOGN'(1);
                    if (asset_q == LastAsset) begin
                        state_d = StDrain;
                    end
                end else begin
                    t_d = t_q + LOGT'(1);
                end
            end
            StDrain: begin
                if (iAbort) begin
                    state_d = StIdle;
                end else if (valid_q == '0) begin
                    state_d = StFinish;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            t_q     <= TMin;
            asset_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            asset_q <= asset_d;
        end
    end

    // Valid/tag delay line; stage PIPE_LAT-1 lines up with the datapath result.
    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = issue;
        for (int j = 1; j < int'(PIPE_LAT); j++) begin
            valid_d[j] = valid_q[j-1];
        end
        if (abort_hit) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int j = 0; j < int'(PIPE_LAT); j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q[0] <= {asset_q, t_q};
            for (int j = 1; j < int'(PIPE_LAT); j++) begin
                tag_q[j] <= tag_q[j-1];
            end
        end
    end

    // Outputs
    assign oIssue   = issue;
    assign oT       = issue ? t_q : '0;
    assign oMu      = issue ? mu_q[asset_q] : '0;
    assign oS       = issue ? s_q[asset_q] : '0;
    // A write maturing in the abort cycle is suppressed along with the rest.
    assign oWrEn    = valid_q[PIPE_LAT-1] && !abort_hit;
    assign oWrAddr  = oWrEn ? tag_q[PIPE_LAT-1] : '0;
    assign oWrData  = iResult;
    assign oBusy    = (state_q != StIdle);
    assign oDone    = (state_q == StFinish);
    assign oAborted = abort_hit;

endmodule
